// File: rtl/dii_package.sv
// Shared DII flit type, egress routing target and subnet helper for the ring router gateway.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    typedef enum logic [1:0] {
        ROUTE_LOCAL,
        ROUTE_EXT,
        ROUTE_RING
    } route_target_t;

    typedef enum logic [1:0] {
        NOWORM,
        WORM_LOCAL,
        WORM_EXT,
        WORM_RING
    } demux_state_t;

    // Subnet number carried in the top subnet_bits of a DII address, right-aligned.
    function automatic logic [15:0] dii_subnet(input logic [15:0] dest, input int unsigned subnet_bits);
        return dest >> (16 - subnet_bits);
    endfunction

endpackage

// File: rtl/dii_skid_buffer.sv
// Two-entry flit FIFO whose upstream ready comes straight from a register (buffer not full).
module dii_skid_buffer
    import dii_package::*;
(
    input  logic    clk,
    input  logic    rst,
    input  dii_flit in_flit,
    output logic    in_ready,
    output dii_flit out_flit,
    input  logic    out_ready
);

    logic [16:0] slot [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic        push;
    logic        pop;

    assign push = in_flit.valid & in_ready;
    assign pop  = (count != 2'd0) & out_ready;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            in_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count    <= count_next;
            in_ready <= (count_next != 2'd2);
        end
    end

    // Payload storage needs no reset: it is only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            slot[wr_ptr] <= {in_flit.last, in_flit.data};
        end
    end

    assign out_flit = '{valid: (count != 2'd0), last: slot[rd_ptr][16], data: slot[rd_ptr][15:0]};

endmodule

// File: rtl/ring_router_gateway_demux.sv
// Egress demux of the ring router gateway: steers whole worms to local, external subnet or ring.
// Optional input skid buffer enabled by RING_ROUTER_GATEWAY_DEMUX_INBUF_EN.
module ring_router_gateway_demux
    import dii_package::*;
#(
    parameter logic [15:0]            NODE_ID      = 16'h0000,
    parameter int unsigned            SUBNET_BITS  = 6,
    parameter logic [SUBNET_BITS-1:0] LOCAL_SUBNET = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  dii_flit      in_ring,
    output logic         in_ring_ready,
    output dii_flit      out_local,
    input  logic         out_local_ready,
    output dii_flit      out_ext,
    input  logic         out_ext_ready,
    output dii_flit      out_ring,
    input  logic         out_ring_ready,
    output demux_state_t state
);

    // Every port pair is a valid/ready handshake: a flit moves on a cycle where valid and
    // ready are both high; valid never waits for ready, and the source holds the flit stable
    // until it is accepted.

    dii_flit       flit;
    logic          flit_valid;
    logic          flit_ready;
    logic          sel_ready;
    route_target_t hdr_target;
    route_target_t target;

`ifdef RING_ROUTER_GATEWAY_DEMUX_INBUF_EN
    dii_skid_buffer u_inbuf (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_ring),
        .in_ready  (in_ring_ready),
        .out_flit  (flit),
        .out_ready (flit_ready)
    );
`else
    assign flit          = in_ring;
    assign in_ring_ready = flit_ready;
`endif

    function automatic route_target_t decode(input logic [15:0] dest);
        if (dest == NODE_ID) begin
            return ROUTE_LOCAL;
        end else if (dii_subnet(dest, SUBNET_BITS) != 16'(LOCAL_SUBNET)) begin
            return ROUTE_EXT;
        end else begin
            return ROUTE_RING;
        end
    endfunction

    assign hdr_target = decode(flit.data);
    assign flit_valid = flit.valid & ~rst;

    // Only the header is decoded; body flits follow the worm recorded in state.
    always_comb begin
        target = hdr_target;
        unique case (state)
            WORM_LOCAL: target = ROUTE_LOCAL;
            WORM_EXT:   target = ROUTE_EXT;
            WORM_RING:  target = ROUTE_RING;
            default:    target = hdr_target;
        endcase
    end

    always_comb begin
        sel_ready = 1'b0;
        unique case (target)
            ROUTE_LOCAL: sel_ready = out_local_ready;
            ROUTE_EXT:   sel_ready = out_ext_ready;
            ROUTE_RING:  sel_ready = out_ring_ready;
            default:     sel_ready = 1'b0;
        endcase
    end

    assign flit_ready = flit_valid & sel_ready;

    assign out_local = '{valid: flit_valid && (target == ROUTE_LOCAL), last: flit.last, data: flit.data};
    assign out_ext   = '{valid: flit_valid && (target == ROUTE_EXT),   last: flit.last, data: flit.data};
    assign out_ring  = '{valid: flit_valid && (target == ROUTE_RING),  last: flit.last, data: flit.data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NOWORM;
        end else if (flit_ready) begin
            if (flit.last) begin
                state <= NOWORM;
            end else begin
                unique case (target)
                    ROUTE_LOCAL: state <= WORM_LOCAL;
                    ROUTE_EXT:   state <= WORM_EXT;
                    ROUTE_RING:  state <= WORM_RING;
                    default:     state <= NOWORM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_router_gateway_demux.sv
// Self-checking bench for ring_router_gateway_demux (NODE_ID 5, 6-bit subnet, local subnet 0).
module tb_ring_router_gateway_demux;
    import dii_package::*;

    logic         clk = 1'b0;
    logic         rst;
    dii_flit      in_ring;
    logic         in_ring_ready;
    dii_flit      out_local;
    logic         out_local_ready;
    dii_flit      out_ext;
    logic         out_ext_ready;
    dii_flit      out_ring;
    logic         out_ring_ready;
    demux_state_t state;

    int passed = 0;
    int total  = 0;

    logic [18:0] in_q [$];
    logic [16:0] exp_local_q [$];
    logic [16:0] exp_ext_q [$];
    logic [16:0] exp_ring_q [$];
    logic [16:0] flits [8];

    typedef struct {
        logic [15:0] dest;
        int          tgt;
    } vec_t;
    vec_t vecs [10];

    ring_router_gateway_demux #(
        .NODE_ID      (16'h0005),
        .SUBNET_BITS  (6),
        .LOCAL_SUBNET (6'd0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_ring         (in_ring),
        .in_ring_ready   (in_ring_ready),
        .out_local       (out_local),
        .out_local_ready (out_local_ready),
        .out_ext         (out_ext),
        .out_ext_ready   (out_ext_ready),
        .out_ring        (out_ring),
        .out_ring_ready  (out_ring_ready),
        .state           (state)
    );

    always #5 clk = ~clk;

    // Reference routing: 0 local, 1 external subnet, 2 ring. Subnet is the address divided by 2^10.
    function automatic int ref_route(input logic [15:0] dest);
        if (dest == 16'h0005) return 0;
        if ((int'(dest) / 1024) != 0) return 1;
        return 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic l, input logic [15:0] d);
        in_ring = '{valid: v, last: l, data: d};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0000);
        out_local_ready = 1'b1;
        out_ext_ready   = 1'b1;
        out_ring_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_outs(input string name, input int tgt, input logic l, input logic [15:0] d,
                              input logic rdy);
        check({name, "_local_v"}, 32'(out_local.valid), 32'(tgt == 0));
        check({name, "_ext_v"},   32'(out_ext.valid),   32'(tgt == 1));
        check({name, "_ring_v"},  32'(out_ring.valid),  32'(tgt == 2));
        check({name, "_ready"},   32'(in_ring_ready),   32'(rdy));
        if (tgt == 0) check({name, "_data"}, 32'({out_local.last, out_local.data}), 32'({l, d}));
        if (tgt == 1) check({name, "_data"}, 32'({out_ext.last, out_ext.data}),     32'({l, d}));
        if (tgt == 2) check({name, "_data"}, 32'({out_ring.last, out_ring.data}),   32'({l, d}));
    endtask

    task automatic pop_compare(input string name, input logic [16:0] act, input int which);
        logic [31:0] e;
        e = 32'hDEAD_0000;
        if (which == 0 && exp_local_q.size() != 0) e = 32'(exp_local_q.pop_front());
        if (which == 1 && exp_ext_q.size() != 0)   e = 32'(exp_ext_q.pop_front());
        if (which == 2 && exp_ring_q.size() != 0)  e = 32'(exp_ring_q.pop_front());
        check(name, 32'(act), e);
    endtask

    task automatic random_test();
        int          len;
        int          tgt;
        int          sel;
        logic [15:0] hdr;
        logic [15:0] d;
        logic        l;
        logic        hold;
        logic        exp_rdy;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 4);
            sel = $urandom_range(0, 2);
            if (sel == 0) hdr = 16'h0005;
            else if (sel == 1) hdr = 16'($urandom_range(0, 1023));
            else hdr = 16'($urandom);
            tgt = ref_route(hdr);
            for (int f = 0; f < len; f++) begin
                d = (f == 0) ? hdr : 16'($urandom);
                l = (f == len - 1);
                in_q.push_back({2'(tgt), l, d});
                if (tgt == 0) exp_local_q.push_back({l, d});
                else if (tgt == 1) exp_ext_q.push_back({l, d});
                else exp_ring_q.push_back({l, d});
            end
        end
        hold = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (in_q.size() == 0 && exp_local_q.size() == 0 && exp_ext_q.size() == 0 && exp_ring_q.size() == 0)
                break;
            if (in_q.size() != 0 && (hold || $urandom_range(0, 3) != 0))
                drive(1'b1, in_q[0][16], in_q[0][15:0]);
            else
                drive(1'b0, 1'b0, 16'($urandom));
            out_local_ready = ($urandom_range(0, 3) != 0);
            out_ext_ready   = ($urandom_range(0, 3) != 0);
            out_ring_ready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
`ifndef RING_ROUTER_GATEWAY_DEMUX_INBUF_EN
            exp_rdy = 1'b0;
            if (in_ring.valid) begin
                if (in_q[0][18:17] == 2'd0) exp_rdy = out_local_ready;
                else if (in_q[0][18:17] == 2'd1) exp_rdy = out_ext_ready;
                else exp_rdy = out_ring_ready;
            end
            check("rand_ready", 32'(in_ring_ready), 32'(exp_rdy));
`endif
            if (out_local.valid && out_local_ready) pop_compare("rand_local", {out_local.last, out_local.data}, 0);
            if (out_ext.valid && out_ext_ready)     pop_compare("rand_ext",   {out_ext.last, out_ext.data}, 1);
            if (out_ring.valid && out_ring_ready)   pop_compare("rand_ring",  {out_ring.last, out_ring.data}, 2);
            if (in_ring.valid) begin
                if (in_ring_ready) begin
                    void'(in_q.pop_front());
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 16'h0000);
        check("rand_all_sent", 32'(in_q.size()), 32'd0);
        check("rand_all_delivered", 32'(exp_local_q.size() + exp_ext_q.size() + exp_ring_q.size()), 32'd0);
    endtask

    initial begin
        int idx;
        int acc;
        int first_acc;
        int first_out;
        int last_out;
        int out_cnt;
        logic [5:0] sched;

        do_reset();
        #1;
        check("reset_state", 32'(state), 32'(NOWORM));
        check_outs("reset_idle", 3, 1'b0, 16'h0000, 1'b0);

`ifndef RING_ROUTER_GATEWAY_DEMUX_INBUF_EN
        vecs[0] = '{16'h0005, 0};
        vecs[1] = '{16'h0407, 1};
        vecs[2] = '{16'hFC00, 1};
        vecs[3] = '{16'h0009, 2};
        vecs[4] = '{16'h0000, 2};
        vecs[5] = '{16'h03FF, 2};
        vecs[6] = '{16'h0400, 1};
        vecs[7] = '{16'h0405, 1};
        vecs[8] = '{16'h8005, 1};
        vecs[9] = '{16'h0004, 2};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, vecs[i].dest);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].tgt, 1'b1, vecs[i].dest, 1'b1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_state", i), 32'(state), 32'(NOWORM));
        end
        drive(1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        #1;

        // 3-flit local worm; body data would decode elsewhere if treated as a header.
        flits[0] = {1'b0, 16'h0005};
        flits[1] = {1'b0, 16'hFC09};
        flits[2] = {1'b1, 16'h0009};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, flits[i][16], flits[i][15:0]);
            #1;
            check_outs($sformatf("worm3_f%0d", i), 0, flits[i][16], flits[i][15:0], 1'b1);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 16'h0000);
        check("worm3_state", 32'(state), 32'(NOWORM));

        // Ring worm with sink backpressure for two cycles on flit 2.
        flits[0] = {1'b0, 16'h0009};
        flits[1] = {1'b0, 16'h1111};
        flits[2] = {1'b0, 16'h0005};
        flits[3] = {1'b1, 16'h3333};
        sched = 6'b110011;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, flits[idx][16], flits[idx][15:0]);
            out_ring_ready = sched[c];
            #1;
            check($sformatf("bp_ready_c%0d", c), 32'(in_ring_ready), 32'(sched[c]));
            check($sformatf("bp_valid_c%0d", c), 32'(out_ring.valid), 32'd1);
            check($sformatf("bp_others_c%0d", c), 32'(out_local.valid | out_ext.valid), 32'd0);
            if (out_ring.valid && out_ring_ready) begin
                check($sformatf("bp_data%0d", idx), 32'({out_ring.last, out_ring.data}), 32'(flits[idx]));
                idx++;
            end
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 16'h0000);
        out_ring_ready = 1'b1;
        check("bp_count", 32'(idx), 32'd4);
        check("bp_state", 32'(state), 32'(NOWORM));

        // Back-to-back: 2-flit local then 1-flit ext, no idle cycle.
        flits[0] = {1'b0, 16'h0005};
        flits[1] = {1'b1, 16'hCAFE};
        flits[2] = {1'b1, 16'hFC00};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, flits[i][16], flits[i][15:0]);
            #1;
            check_outs($sformatf("b2b_f%0d", i), (i < 2) ? 0 : 1, flits[i][16], flits[i][15:0], 1'b1);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 16'h0000);

        // Reset during flit 2 of a local worm; the following header must be decoded afresh.
        drive(1'b1, 1'b0, 16'h0005);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 1'b0, 16'h1234);
        #1;
        check_outs("rst_mid", 3, 1'b0, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_state", 32'(state), 32'(NOWORM));
        drive(1'b1, 1'b1, 16'h0009);
        #1;
        check_outs("rst_next", 2, 1'b1, 16'h0009, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h0000);
`else
        // 8-flit local stream through the input buffer.
        idx = 0;
        first_acc = -1;
        first_out = -1;
        last_out = -1;
        out_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (idx < 8) drive(1'b1, idx == 7, (idx == 0) ? 16'h0005 : 16'(16'hA000 + idx));
            else drive(1'b0, 1'b0, 16'h0000);
            @(negedge clk);
            if (out_local.valid) begin
                check($sformatf("buf_data%0d", out_cnt), 32'({out_local.last, out_local.data}),
                      32'({out_cnt == 7, (out_cnt == 0) ? 16'h0005 : 16'(16'hA000 + out_cnt)}));
                if (first_out < 0) first_out = c;
                last_out = c;
                out_cnt++;
            end
            if (in_ring.valid && in_ring_ready) begin
                if (first_acc < 0) first_acc = c;
                idx++;
            end
            @(posedge clk);
            #1;
        end
        check("buf_latency", 32'(first_out - first_acc), 32'd1);
        check("buf_out_count", 32'(out_cnt), 32'd8);
        check("buf_throughput", 32'(last_out - first_out), 32'd7);

        // Buffer fill under output backpressure.
        out_local_ready = 1'b0;
        idx = 0;
        acc = 0;
        out_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 6) begin
                check("fill_accepted", 32'(acc), 32'd2);
                check("fill_ready_low", 32'(in_ring_ready), 32'd0);
                out_local_ready = 1'b1;
            end
            if (idx < 4) drive(1'b1, idx == 3, (idx == 0) ? 16'h0005 : 16'(16'hB000 + idx));
            else drive(1'b0, 1'b0, 16'h0000);
            @(negedge clk);
            if (out_local.valid && out_local_ready) begin
                check($sformatf("fill_data%0d", out_cnt), 32'({out_local.last, out_local.data}),
                      32'({out_cnt == 3, (out_cnt == 0) ? 16'h0005 : 16'(16'hB000 + out_cnt)}));
                out_cnt++;
            end
            if (in_ring.valid && in_ring_ready) begin
                idx++;
                acc++;
            end
            @(posedge clk);
            #1;
        end
        check("fill_out_count", 32'(out_cnt), 32'd4);
`endif

        do_reset();
        random_test();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
